// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared ALU opcodes, forward selects and multiplier state type
package execute_stage_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SRL  = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// rtl/execute_stage_mul_iter.sv - iterative shift-add multiplier (mul_iter), built only with EXECUTE_MUL_EN
`ifdef EXECUTE_MUL_EN
module mul_iter
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN + 1);

    mul_state_t      state;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            step    <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= BUSY;
                    mcand   <= a;
                    mplier  <= b;
                    product <= '0;
                    step    <= '0;
                end
                BUSY: begin
                    // Only the low XLEN bits are kept, so the shifted multiplicand may drop its top bits.
                    if (mplier[0]) product <= product + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + CW'(1);
                    if (step == CW'(XLEN - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule
`endif

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: forwarding, ALU, branch resolve, E/M register
// Optional iterative multiply enabled by defining EXECUTE_MUL_EN.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BeqE,
    input  logic            BneE,
    input  logic            BltE,
    input  logic            BgeE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic            MulE,
    input  logic [XLEN-1:0] Rd1E,
    input  logic [XLEN-1:0] Rd2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            StallE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result;
    logic            zero, lt, taken;

    always_comb begin
        case (ForwardAE)
            FWD_REG: src_a = Rd1E;
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = Rd1E;
        endcase
        case (ForwardBE)
            FWD_REG: write_data_e = Rd2E;
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ALUResultM;
            default: write_data_e = Rd2E;
        endcase
    end

    assign src_b = ALUSrcE ? ExtImmE : write_data_e;
    assign zero  = (src_a == src_b);
    assign lt    = ($signed(src_a) < $signed(src_b));
    assign taken = (BeqE & zero) | (BneE & ~zero) | (BltE & lt) | (BgeE & ~lt);

    always_comb begin
        case (ALUControlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SRL:  alu_result = src_a >> src_b[4:0];
            default:  alu_result = '0;
        endcase
    end

    assign PCTargetE = PCE + ExtImmE;

    logic            mul_done;
    logic [XLEN-1:0] product;
    logic            lat_rw;
    logic [1:0]      lat_rs;
    logic [4:0]      lat_rd;
    logic [XLEN-1:0] lat_pc4;

`ifdef EXECUTE_MUL_EN
    logic mul_busy, mul_idle, accept;

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign mul_idle = ~mul_busy & ~mul_done;
    assign accept   = mul_idle & MulE;
    assign StallE   = rst & (accept | mul_busy);
    // A multiply outranks any jump/branch flags presented alongside it.
    assign PCSrcE   = mul_idle & ~MulE & (JumpE | taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_rw  <= 1'b0;
            lat_rs  <= '0;
            lat_rd  <= '0;
            lat_pc4 <= '0;
        end else if (accept) begin
            lat_rw  <= RegWriteE;
            lat_rs  <= ResultSrcE;
            lat_rd  <= RdE;
            lat_pc4 <= PCPlus4E;
        end
    end
`else
    logic unused_mul;

    assign unused_mul = MulE;
    assign StallE     = 1'b0;
    assign PCSrcE     = JumpE | taken;
    assign mul_done   = 1'b0;
    assign product    = '0;
    assign lat_rw     = 1'b0;
    assign lat_rs     = '0;
    assign lat_rd     = '0;
    assign lat_pc4    = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (mul_done) begin
            RegWriteM  <= lat_rw;
            MemWriteM  <= 1'b0;
            ResultSrcM <= lat_rs;
            RdM        <= lat_rd;
            ALUResultM <= product;
            PCPlus4M   <= lat_pc4;
        end else if (StallE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= alu_result;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage, both EXECUTE_MUL_EN builds
module tb_execute_stage;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    logic RegWriteE, MemWriteE, JumpE, BeqE, BneE, BltE, BgeE, ALUSrcE, MulE;
    logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0] ALUControlE;
    logic [31:0] Rd1E, Rd2E, PCE, ExtImmE, PCPlus4E, ResultW;
    logic [4:0] RdE;
    logic PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0] ResultSrcM;
    logic [4:0] RdM;

    execute_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BeqE(BeqE), .BneE(BneE), .BltE(BltE), .BgeE(BgeE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .MulE(MulE), .Rd1E(Rd1E),
        .Rd2E(Rd2E), .PCE(PCE), .ExtImmE(ExtImmE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rw, mw, jmp, beq, bne, blt, bge, alusrc, mul;
        logic [1:0]  rs, fa, fb;
        logic [2:0]  op;
        logic [31:0] rd1, rd2, pc, imm, pc4, resw;
        logic [4:0]  rd;
    } ins_t;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } em_t;

    typedef struct packed {
        logic        chk_pc;
        logic        chk_zero;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
    } comb_t;

    comb_t comb_q[$];
    em_t   em_q[$];
    int    checks = 0;
    int    errors = 0;

    em_t         m_em;
    int          mul_left;
    logic [31:0] mul_prod, l_pc4;
    logic        l_rw;
    logic [1:0]  l_rs;
    logic [4:0]  l_rd;

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return a >> sh;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] rand_val(input logic [31:0] other);
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return -32'($urandom_range(1, 8));
            2: return $urandom;
            default: return other;
        endcase
    endfunction

    function automatic ins_t nop_ins();
        ins_t i;
        i = '{rst: 1'b1, default: '0};
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i = nop_ins();
        i.rw = 1'($urandom); i.mw = 1'($urandom); i.alusrc = 1'($urandom);
        i.jmp = ($urandom_range(0, 5) == 0);
        i.beq = ($urandom_range(0, 3) == 0); i.bne = ($urandom_range(0, 3) == 0);
        i.blt = ($urandom_range(0, 3) == 0); i.bge = ($urandom_range(0, 3) == 0);
        i.rs = 2'($urandom); i.fa = 2'($urandom); i.fb = 2'($urandom);
        i.op = 3'($urandom); i.rd = 5'($urandom);
        i.rd1 = rand_val($urandom); i.rd2 = rand_val(i.rd1);
        i.imm = rand_val(i.rd1); i.resw = rand_val(i.rd1);
        i.pc = $urandom; i.pc4 = $urandom;
        return i;
    endfunction

    task automatic step(input ins_t i);
        comb_t c;
        logic [31:0] a, wd, b;
        logic lt, taken;
        @(negedge clk);
        rst = i.rst; RegWriteE = i.rw; MemWriteE = i.mw; JumpE = i.jmp; BeqE = i.beq;
        BneE = i.bne; BltE = i.blt; BgeE = i.bge; ALUSrcE = i.alusrc; MulE = i.mul;
        ResultSrcE = i.rs; ForwardAE = i.fa; ForwardBE = i.fb; ALUControlE = i.op;
        Rd1E = i.rd1; Rd2E = i.rd2; PCE = i.pc; ExtImmE = i.imm; PCPlus4E = i.pc4;
        ResultW = i.resw; RdE = i.rd;
        a  = fwd(i.fa, i.rd1, i.resw, m_em.alu);
        wd = fwd(i.fb, i.rd2, i.resw, m_em.alu);
        b  = i.alusrc ? i.imm : wd;
        lt = ($signed(a) < $signed(b));
        taken = (i.beq && a == b) || (i.bne && a != b) || (i.blt && lt) || (i.bge && !lt);
        c.tgt = i.pc + i.imm;
        c.chk_pc = 1'b1;
        c.chk_zero = 1'b0;
        if (!i.rst) begin
            m_em = '0; mul_left = 0;
            c.chk_pc = 1'b0; c.chk_zero = 1'b1; c.stall = 1'b0; c.pcsrc = 1'b0;
        end
`ifdef EXECUTE_MUL_EN
        else if (mul_left > 0) begin
            mul_left--;
            c.pcsrc = 1'b0;
            c.stall = (mul_left != 0);
            if (mul_left == 0) begin
                m_em.alu = mul_prod; m_em.rd = l_rd; m_em.rw = l_rw;
                m_em.rs = l_rs; m_em.pc4 = l_pc4; m_em.mw = 1'b0;
            end else begin
                m_em.rw = 1'b0; m_em.mw = 1'b0;
            end
        end else if (i.mul) begin
            mul_prod = a * b;
            l_rd = i.rd; l_rw = i.rw; l_rs = i.rs; l_pc4 = i.pc4;
            mul_left = XLEN + 1;
            c.stall = 1'b1; c.pcsrc = 1'b0;
            m_em.rw = 1'b0; m_em.mw = 1'b0;
        end
`endif
        else begin
            c.stall = 1'b0;
            c.pcsrc = i.jmp || taken;
            m_em.rw = i.rw; m_em.mw = i.mw; m_em.rs = i.rs; m_em.rd = i.rd;
            m_em.alu = model_alu(i.op, a, b); m_em.wd = wd; m_em.pc4 = i.pc4;
        end
        comb_q.push_back(c);
        em_q.push_back(m_em);
    endtask

    comb_t mc;
    em_t   me, ge;

    initial forever begin
        @(negedge clk);
        #2;
        if (comb_q.size() > 0) begin
            mc = comb_q.pop_front();
            checks++;
            if (StallE !== mc.stall) begin
                errors++;
                $display("FAIL stall t=%0t: got %b exp %b", $time, StallE, mc.stall);
            end
            if (mc.chk_pc) begin
                checks++;
                if (PCSrcE !== mc.pcsrc || PCTargetE !== mc.tgt) begin
                    errors++;
                    $display("FAIL redirect t=%0t: got pcsrc=%b tgt=%h exp pcsrc=%b tgt=%h",
                             $time, PCSrcE, PCTargetE, mc.pcsrc, mc.tgt);
                end
            end
            if (mc.chk_zero) begin
                checks++;
                ge = {RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M};
                if (ge !== '0) begin
                    errors++;
                    $display("FAIL async_clear t=%0t: got %h exp 0", $time, ge);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (em_q.size() > 0) begin
            me = em_q.pop_front();
            ge = {RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M};
            checks++;
            if (ge !== me) begin
                errors++;
                $display("FAIL em_reg t=%0t: got rw=%b mw=%b rs=%0d rd=%0d alu=%h wd=%h pc4=%h exp rw=%b mw=%b rs=%0d rd=%0d alu=%h wd=%h pc4=%h",
                         $time, ge.rw, ge.mw, ge.rs, ge.rd, ge.alu, ge.wd, ge.pc4,
                         me.rw, me.mw, me.rs, me.rd, me.alu, me.wd, me.pc4);
            end
        end
    end

    initial begin
        ins_t i;
        m_em = '0; mul_left = 0; mul_prod = '0;
        l_rw = 1'b0; l_rs = '0; l_rd = '0; l_pc4 = '0;
        i = nop_ins(); i.rst = 1'b0; i.mul = 1'b1; i.jmp = 1'b1;
        rst = 1'b0; MulE = 1'b0;
        step(i); step(i);

        i = nop_ins(); i.rw = 1; i.rd = 5'd3; i.rd1 = 32'd5; i.imm = 32'd7; i.alusrc = 1;
        step(i);
        i = nop_ins(); i.rw = 1; i.rd1 = 32'h8; i.imm = 32'h8; i.alusrc = 1;
        step(i);
        i = nop_ins(); i.rw = 1; i.fa = 2'b10; i.rd2 = 32'd3; i.op = 3'b001;
        step(i);
        i = nop_ins(); i.rd1 = 32'hFFFF_FFFF; i.rd2 = 32'd1; i.blt = 1; i.pc = 32'h100; i.imm = 32'h20;
        step(i);

`ifdef EXECUTE_MUL_EN
        i = nop_ins(); i.mul = 1; i.jmp = 1; i.rw = 1; i.rd = 5'd9; i.rd1 = 32'd6; i.rd2 = 32'd7; i.pc4 = 32'h44;
        for (int k = 0; k < XLEN + 2; k++) step(i);
        for (int n = 0; n < 150; n++) step(rand_ins());
        for (int m = 0; m < 3; m++) begin
            i = rand_ins(); i.mul = 1;
            step(i);
            for (int k = 0; k < XLEN + 1; k++) begin
                i.fa = 2'($urandom); i.fb = 2'($urandom); i.resw = $urandom;
                step(i);
            end
            step(rand_ins());
        end
        i = nop_ins(); i.mul = 1; i.rw = 1; i.rd1 = 32'd123; i.rd2 = 32'd456;
        for (int k = 0; k < 11; k++) step(i);
        i.rst = 1'b0;
        step(i);
        i = nop_ins(); i.rw = 1; i.rd = 5'd4; i.rd1 = 32'd20; i.imm = 32'd22; i.alusrc = 1;
        step(i);
`else
        i = nop_ins(); i.mul = 1; i.rw = 1; i.rd1 = 32'd6; i.rd2 = 32'd7;
        step(i);
        for (int n = 0; n < 250; n++) begin
            i = rand_ins(); i.mul = 1'($urandom);
            step(i);
        end
`endif
        for (int n = 0; n < 20; n++) step(rand_ins());
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (comb_q.size() != 0 || em_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending exp 0/0", comb_q.size(), em_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
